// File: rtl/ball_motion_ctrl.sv
// Frame-synchronous ball motion controller: Avalon-MM shadow registers, per-frame bounce update at vblank.
// Optional frame-done interrupt enabled by defining BALL_IRQ_EN.
`timescale 1ns/1ps
module ball_motion_ctrl #(
  parameter int H_MAX  = 1280,
  parameter int V_MAX  = 480,
  parameter int X_INIT = 640,
  parameter int Y_INIT = 100,
  parameter int R_INIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [3:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  input  logic        vblank_start,
  output logic [10:0] ball_x,
  output logic [9:0]  ball_y,
  output logic [7:0]  ball_r,
  output logic        busy,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, CALC_X, CALC_Y, COMMIT} state_t;
  state_t state, state_next;

  logic              run, step, load_pend, use_load, overrun;
  logic signed [7:0] vx, vy, vx_new, vy_new;
  logic [7:0]        radius, r_lat, frame_cnt, rdata;
  logic [10:0]       posx, x_calc, x_new, x_load;
  logic [9:0]        posy, y_calc, y_new, y_load;
  logic              wr, rd, wr_ctrl;

  // 13-bit signed working width so an 11-bit loaded position plus velocity cannot wrap.
  logic signed [12:0] bx, nx, rx, hx, by, ny, ry, hy, px, py, rxl, hxl;

  assign wr      = chipselect & write;
  assign rd      = chipselect & read;
  assign wr_ctrl = wr && (address == 4'd0);

  function automatic logic signed [7:0] neg(input logic signed [7:0] v);
    return (v == 8'sh80) ? 8'sh7F : -v;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (vblank_start && (run || step)) state_next = CALC_X;
      CALC_X:  state_next = CALC_Y;
      CALC_Y:  state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // X uses the live shadow radius (the value latched this cycle); Y uses the latched copy.
  always_comb begin
    bx     = {2'b00, (load_pend ? posx : ball_x)};
    nx     = bx + {{5{vx[7]}}, vx};
    rx     = {5'b0, radius};
    hx     = 13'(H_MAX - 1) - rx;
    x_new  = nx[10:0];
    vx_new = vx;
    if (nx < rx) begin
      x_new  = rx[10:0];
      vx_new = neg(vx);
    end else if (nx > hx) begin
      x_new  = hx[10:0];
      vx_new = neg(vx);
    end

    by     = {3'b000, (use_load ? posy : ball_y)};
    ny     = by + {{5{vy[7]}}, vy};
    ry     = {6'b0, r_lat[7:1]};
    hy     = 13'(V_MAX - 1) - ry;
    y_new  = ny[9:0];
    vy_new = vy;
    if (ny < ry) begin
      y_new  = ry[9:0];
      vy_new = neg(vy);
    end else if (ny > hy) begin
      y_new  = hy[9:0];
      vy_new = neg(vy);
    end

    px     = {2'b00, posx};
    rxl    = {5'b0, r_lat};
    hxl    = 13'(H_MAX - 1) - rxl;
    x_load = (px < rxl) ? rxl[10:0] : (px > hxl) ? hxl[10:0] : posx;
    py     = {3'b000, posy};
    y_load = (py < ry) ? ry[9:0] : (py > hy) ? hy[9:0] : posy;
  end

  always_comb begin
    rdata = '0;
    case (address)
      4'd0: rdata = {6'b0, step, run};
      4'd1: rdata = vx;
      4'd2: rdata = vy;
      4'd3: rdata = radius;
      4'd4: rdata = posx[7:0];
      4'd5: rdata = {5'b0, posx[10:8]};
      4'd6: rdata = posy[7:0];
      4'd7: rdata = {6'b0, posy[9:8]};
      4'd8: rdata = {5'b0, irq, overrun, busy};
      4'd9: rdata = frame_cnt;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ball_x    <= 11'(X_INIT);
      ball_y    <= 10'(Y_INIT);
      ball_r    <= 8'(R_INIT);
      run       <= 1'b0;
      step      <= 1'b0;
      load_pend <= 1'b0;
      use_load  <= 1'b0;
      overrun   <= 1'b0;
      vx        <= '0;
      vy        <= '0;
      radius    <= 8'(R_INIT);
      r_lat     <= 8'(R_INIT);
      posx      <= 11'(X_INIT);
      posy      <= 10'(Y_INIT);
      x_calc    <= '0;
      y_calc    <= '0;
      frame_cnt <= '0;
      readdata  <= '0;
    end else begin
      case (state)
        CALC_X: begin
          r_lat    <= radius;
          use_load <= load_pend;
          x_calc   <= x_new;
        end
        CALC_Y: y_calc <= y_new;
        COMMIT: begin
          ball_x    <= use_load ? x_load : x_calc;
          ball_y    <= use_load ? y_load : y_calc;
          ball_r    <= r_lat;
          frame_cnt <= frame_cnt + 8'd1;
        end
        default: ;
      endcase

      // Software writes take priority over the update's own write-backs and clears.
      if (wr && address == 4'd1)      vx <= writedata;
      else if (state == CALC_X)       vx <= vx_new;
      if (wr && address == 4'd2)      vy <= writedata;
      else if (state == CALC_Y)       vy <= vy_new;

      if (wr_ctrl)                    run <= writedata[0];
      if (wr_ctrl && writedata[1])    step <= 1'b1;
      else if (state == COMMIT)       step <= 1'b0;

      if (wr && (address == 4'd5 || address == 4'd7)) load_pend <= 1'b1;
      else if (state == COMMIT)                       load_pend <= 1'b0;

      if (wr && address == 4'd3) radius     <= (writedata == 8'd0) ? 8'd1 : writedata;
      if (wr && address == 4'd4) posx[7:0]  <= writedata;
      if (wr && address == 4'd5) posx[10:8] <= writedata[2:0];
      if (wr && address == 4'd6) posy[7:0]  <= writedata;
      if (wr && address == 4'd7) posy[9:8]  <= writedata[1:0];

      if (vblank_start && state != IDLE) overrun <= 1'b1;
      else if (rd && address == 4'd8)    overrun <= 1'b0;

      if (rd) readdata <= rdata;
    end
  end

`ifdef BALL_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         irq_q <= 1'b0;
    else if (state == COMMIT)          irq_q <= 1'b1;
    else if (wr_ctrl && writedata[2])  irq_q <= 1'b0;
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Self-checking bench for ball_motion_ctrl: scoreboard of expected committed positions per frame.
`timescale 1ns/1ps
module tb_ball_motion_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0, write = 1'b0, read = 1'b0;
  logic [3:0]  address = '0;
  logic [7:0]  writedata = '0;
  logic [7:0]  readdata;
  logic        vblank_start = 1'b0;
  logic [10:0] ball_x;
  logic [9:0]  ball_y;
  logic [7:0]  ball_r;
  logic        busy, irq;

`ifdef BALL_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  ball_motion_ctrl #(.H_MAX(1280), .V_MAX(480), .X_INIT(640), .Y_INIT(100), .R_INIT(16)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .vblank_start(vblank_start), .ball_x(ball_x), .ball_y(ball_y), .ball_r(ball_r),
    .busy(busy), .irq(irq)
  );

  always #10 clk = ~clk;

  typedef struct { logic [10:0] x; logic [9:0] y; logic [7:0] r; } exp_t;
  exp_t sb[$];
  exp_t last;
  int checks = 0;
  int errors = 0;

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic push_exp(input int x, input int y, input int r);
    exp_t e;
    e.x = 11'(x); e.y = 10'(y); e.r = 8'(r);
    sb.push_back(e);
  endtask

  // Pulse vblank for 'hold' cycles; outputs must hold until the third edge after the pulse.
  task automatic frame(input string name, input bit active, input int hold);
    exp_t e;
    vblank_start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (k + 1 >= hold) vblank_start = 1'b0;
      checks++;
      if ({busy, ball_x, ball_y, ball_r} !== {active, last.x, last.y, last.r}) begin
        errors++;
        $display("FAIL %s_mid%0d busy/x/y/r got %0b/%0d/%0d/%0d want %0b/%0d/%0d/%0d", name, k,
                 busy, ball_x, ball_y, ball_r, active, last.x, last.y, last.r);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_sb empty scoreboard", name);
    end else begin
      e = sb.pop_front();
      if ({busy, ball_x, ball_y, ball_r} !== {1'b0, e.x, e.y, e.r}) begin
        errors++;
        $display("FAIL %s_commit busy/x/y/r got %0b/%0d/%0d/%0d want 0/%0d/%0d/%0d", name,
                 busy, ball_x, ball_y, ball_r, e.x, e.y, e.r);
      end
      last = e;
    end
  endtask

  task automatic test_reset;
    logic [7:0] d;
    checks++;
    if ({ball_x, ball_y, ball_r, busy, irq, readdata} !== {11'd640, 10'd100, 8'd16, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_outputs got x=%0d y=%0d r=%0d busy=%0b irq=%0b rd=%0d want 640/100/16/0/0/0",
               ball_x, ball_y, ball_r, busy, irq, readdata);
    end
    rd(4'd0, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %h want 00", d); end
    push_exp(640, 100, 16);
    frame("idle_vblank", 1'b0, 1);
    rd(4'd9, d);
    checks++;
    if (d !== 8'd0) begin errors++; $display("FAIL idle_framecnt got %0d want 0", d); end
  endtask

  task automatic test_run;
    logic [7:0] d;
    wr(4'd1, 8'd4);
    wr(4'd2, 8'hFE);
    wr(4'd0, 8'h01);
    push_exp(644, 98, 16);
    push_exp(648, 96, 16);
    push_exp(652, 94, 16);
    frame("run1", 1'b1, 1);
    frame("run2", 1'b1, 1);
    frame("run3", 1'b1, 1);
    rd(4'd9, d);
    checks++;
    if (d !== 8'd3) begin errors++; $display("FAIL run_framecnt got %0d want 3", d); end
    wr(4'd0, 8'h00);
  endtask

  task automatic test_bounce_right;
    logic [7:0] d;
    wr(4'd1, 8'd10);
    wr(4'd2, 8'd0);
    wr(4'd4, 8'hF6);
    wr(4'd5, 8'h04);
    wr(4'd0, 8'h01);
    push_exp(1263, 100, 16);
    frame("bounce_r1", 1'b1, 1);
    rd(4'd1, d);
    checks++;
    if (d !== 8'hF6) begin errors++; $display("FAIL bounce_r_vx got %h want f6", d); end
    push_exp(1253, 100, 16);
    frame("bounce_r2", 1'b1, 1);
    wr(4'd0, 8'h00);
    rd(4'd9, d);
    checks++;
    if (d !== 8'd5) begin errors++; $display("FAIL bounce_r_framecnt got %0d want 5", d); end
  endtask

  task automatic test_step_neg128;
    logic [7:0] d;
    wr(4'd1, 8'h80);
    wr(4'd4, 8'd20);
    wr(4'd5, 8'd0);
    wr(4'd0, 8'h02);
    push_exp(20, 100, 16);
    frame("step_left", 1'b1, 1);
    rd(4'd1, d);
    checks++;
    if (d !== 8'h7F) begin errors++; $display("FAIL neg128_vx got %h want 7f", d); end
    rd(4'd0, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL step_clear got %h want 00", d); end
    checks++;
    if (irq !== IRQ_ON) begin errors++; $display("FAIL irq_set got %0b want %0b", irq, IRQ_ON); end
    push_exp(20, 100, 16);
    frame("step_once", 1'b0, 1);
    rd(4'd8, d);
    checks++;
    if (d !== {5'b0, IRQ_ON, 2'b00}) begin
      errors++; $display("FAIL status_irq got %h want %h", d, {5'b0, IRQ_ON, 2'b00});
    end
    wr(4'd0, 8'h04);
    rd(4'd8, d);
    checks++;
    if (d !== 8'h00 || irq !== 1'b0) begin
      errors++; $display("FAIL irq_clr status %h irq %0b want 00/0", d, irq);
    end
  endtask

  task automatic test_regs;
    logic [7:0] d;
    wr(4'd3, 8'd0);
    rd(4'd3, d);
    checks++;
    if (d !== 8'd1) begin errors++; $display("FAIL radius_zero got %0d want 1", d); end
    wr(4'd3, 8'd16);
    wr(4'd12, 8'hAA);
    rd(4'd12, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reserved_read got %h want 00", d); end
  endtask

  task automatic test_overrun;
    logic [7:0] d;
    wr(4'd0, 8'h01);
    push_exp(147, 100, 16);
    frame("overrun", 1'b1, 2);
    wr(4'd0, 8'h00);
    rd(4'd8, d);
    checks++;
    if (d !== {5'b0, IRQ_ON, 2'b10}) begin
      errors++; $display("FAIL overrun_set got %h want %h", d, {5'b0, IRQ_ON, 2'b10});
    end
    rd(4'd8, d);
    checks++;
    if (d !== {5'b0, IRQ_ON, 2'b00}) begin
      errors++; $display("FAIL overrun_clr got %h want %h", d, {5'b0, IRQ_ON, 2'b00});
    end
    rd(4'd9, d);
    checks++;
    if (d !== 8'd7) begin errors++; $display("FAIL overrun_framecnt got %0d want 7", d); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    wr(4'd1, 8'd5);
    wr(4'd0, 8'h01);
    vblank_start = 1'b1;
    @(posedge clk); #1;
    vblank_start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_mid_busy got %0b want 1", busy); end
    reset = 1'b1;
    #1;
    checks++;
    if ({ball_x, ball_y, ball_r, busy, irq} !== {11'd640, 10'd100, 8'd16, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_outputs got %0d/%0d/%0d busy=%0b irq=%0b want 640/100/16/0/0",
               ball_x, ball_y, ball_r, busy, irq);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    rd(4'd9, d);
    checks++;
    if (d !== 8'd0) begin errors++; $display("FAIL reset_mid_framecnt got %0d want 0", d); end
    rd(4'd1, d);
    checks++;
    if (d !== 8'd0) begin errors++; $display("FAIL reset_mid_vx got %0d want 0", d); end
  endtask

  initial begin
    last.x = 11'd640; last.y = 10'd100; last.r = 8'd16;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_run();
    test_bounce_right();
    test_step_neg128();
    test_regs();
    test_overrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
